// File: rtl/fm_discriminator_pkg.sv
// Shared constants and state type for the FM/GFSK discriminator datapath.
// Default widths match the transmit VCO so IQ_BIT_WIDTH stays consistent.
package fm_discriminator_pkg;

  localparam int DEFAULT_IQ_BIT_WIDTH   = 8;
  localparam int DEFAULT_DISC_BIT_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } disc_state_e;

endpackage

// File: rtl/fm_discriminator_iq_cross_mult.sv
// Registered pair of signed multiplies forming the two halves of a conjugate
// cross product (cur_q*ref_i and cur_i*ref_q), with valid/last tags alongside.
module iq_cross_mult
  import fm_discriminator_pkg::*;
#(
  parameter int IQ_BIT_WIDTH = DEFAULT_IQ_BIT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic signed [IQ_BIT_WIDTH-1:0]  cur_i,
  input  logic signed [IQ_BIT_WIDTH-1:0]  cur_q,
  input  logic signed [IQ_BIT_WIDTH-1:0]  ref_i,
  input  logic signed [IQ_BIT_WIDTH-1:0]  ref_q,
  output logic signed [2*IQ_BIT_WIDTH-1:0] prod_cur_q_ref_i,
  output logic signed [2*IQ_BIT_WIDTH-1:0] prod_cur_i_ref_q,
  output logic                            out_valid,
  output logic                            out_last
);

  localparam int PROD_W = 2 * IQ_BIT_WIDTH;

  logic signed [PROD_W-1:0] prod_a_d, prod_a_q;
  logic signed [PROD_W-1:0] prod_b_d, prod_b_q;
  logic                     valid_d, valid_q;
  logic                     last_d, last_q;

  // Products only update on a strobe so the downstream subtractor stays quiet.
  always_comb begin
    prod_a_d = prod_a_q;
    prod_b_d = prod_b_q;
    valid_d  = in_valid;
    last_d   = in_valid & in_last;
    if (in_valid) begin
      prod_a_d = cur_q * ref_i;
      prod_b_d = cur_i * ref_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_a_q <= '0;
      prod_b_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign prod_cur_q_ref_i = prod_a_q;
  assign prod_cur_i_ref_q = prod_b_q;
  assign out_valid        = valid_q;
  assign out_last         = last_q;

endmodule

// File: rtl/fm_discriminator.sv
// Baseband FM/GFSK discriminator: per-sample phase increment from the conjugate
// cross product of consecutive I/Q samples, saturated and hard-sliced.
module fm_discriminator
  import fm_discriminator_pkg::*;
#(
  parameter int IQ_BIT_WIDTH   = DEFAULT_IQ_BIT_WIDTH,
  parameter int DISC_BIT_WIDTH = DEFAULT_DISC_BIT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic signed [IQ_BIT_WIDTH-1:0]   i_in,
  input  logic signed [IQ_BIT_WIDTH-1:0]   q_in,
  input  logic                             iq_valid,
  input  logic                             iq_valid_last,
  output logic signed [DISC_BIT_WIDTH-1:0] disc_out,
  output logic                             bit_out,
  output logic                             disc_valid,
  output logic                             disc_valid_last
);

  localparam int PROD_W = 2 * IQ_BIT_WIDTH;
  localparam int FULL_W = 2 * IQ_BIT_WIDTH + 1;

  localparam logic signed [FULL_W-1:0] SAT_MAX =
    {{(FULL_W-DISC_BIT_WIDTH+1){1'b0}}, {(DISC_BIT_WIDTH-1){1'b1}}};
  localparam logic signed [FULL_W-1:0] SAT_MIN =
    {{(FULL_W-DISC_BIT_WIDTH+1){1'b1}}, {(DISC_BIT_WIDTH-1){1'b0}}};

  // Clamp to the output range; the low bits of SAT_MAX/SAT_MIN are the rails.
  function automatic logic signed [DISC_BIT_WIDTH-1:0] saturate(
    input logic signed [FULL_W-1:0] x
  );
    logic signed [FULL_W-1:0] clamped;
    clamped = x;
    if (x > SAT_MAX) clamped = SAT_MAX;
    else if (x < SAT_MIN) clamped = SAT_MIN;
    return clamped[DISC_BIT_WIDTH-1:0];
  endfunction

  disc_state_e state_d, state_q;
  logic signed [IQ_BIT_WIDTH-1:0] prev_i_d, prev_i_q;
  logic signed [IQ_BIT_WIDTH-1:0] prev_q_d, prev_q_q;

  logic                           mult_valid;
  logic                           mult_last;
  logic signed [IQ_BIT_WIDTH-1:0] mult_ref_i;
  logic signed [IQ_BIT_WIDTH-1:0] mult_ref_q;

  logic signed [PROD_W-1:0] prod_a;
  logic signed [PROD_W-1:0] prod_b;
  logic                     s1_valid;
  logic                     s1_last;

  logic signed [FULL_W-1:0]         diff;
  logic signed [DISC_BIT_WIDTH-1:0] sat_val;

  logic signed [DISC_BIT_WIDTH-1:0] disc_d, disc_q;
  logic                             bit_d, bit_q;
  logic                             valid_d, valid_q;
  logic                             last_d, last_q;

  // A lone sample in IDLE is crossed against zero so its output is exactly 0.
  always_comb begin
    state_d    = state_q;
    prev_i_d   = prev_i_q;
    prev_q_d   = prev_q_q;
    mult_valid = 1'b0;
    mult_last  = 1'b0;
    mult_ref_i = prev_i_q;
    mult_ref_q = prev_q_q;
    if (iq_valid) begin
      prev_i_d  = i_in;
      prev_q_d  = q_in;
      mult_last = iq_valid_last;
      case (state_q)
        ST_IDLE: begin
          if (iq_valid_last) begin
            mult_valid = 1'b1;
            mult_ref_i = '0;
            mult_ref_q = '0;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          mult_valid = 1'b1;
          if (iq_valid_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prev_i_q <= '0;
      prev_q_q <= '0;
    end else begin
      state_q  <= state_d;
      prev_i_q <= prev_i_d;
      prev_q_q <= prev_q_d;
    end
  end

  iq_cross_mult #(
    .IQ_BIT_WIDTH(IQ_BIT_WIDTH)
  ) u_cross_mult (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (mult_valid),
    .in_last          (mult_last),
    .cur_i            (i_in),
    .cur_q            (q_in),
    .ref_i            (mult_ref_i),
    .ref_q            (mult_ref_q),
    .prod_cur_q_ref_i (prod_a),
    .prod_cur_i_ref_q (prod_b),
    .out_valid        (s1_valid),
    .out_last         (s1_last)
  );

  // Output stage holds the last decision between strobes.
  always_comb begin
    diff    = {prod_a[PROD_W-1], prod_a} - {prod_b[PROD_W-1], prod_b};
    sat_val = saturate(diff);
    disc_d  = disc_q;
    bit_d   = bit_q;
    valid_d = s1_valid;
    last_d  = s1_valid & s1_last;
    if (s1_valid) begin
      disc_d = sat_val;
      bit_d  = (sat_val != '0) && !sat_val[DISC_BIT_WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disc_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      disc_q  <= disc_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign disc_out        = disc_q;
  assign bit_out         = bit_q;
  assign disc_valid      = valid_q;
  assign disc_valid_last = last_q;

endmodule
